// File: rtl/config_tree_accumulator_pkg.sv
// Shared types and saturation limits for the tree-adder result accumulator.
package config_tree_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  // Largest positive two's-complement value of width w, as raw bits.
  function automatic logic [63:0] acc_max_bits(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w, as raw bits.
  function automatic logic [63:0] acc_min_bits(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/config_tree_accumulator_if.sv
// Beat-in / result-out stream bundle between the tree adder and write-back.
interface config_tree_accumulator_if #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned K_WIDTH   = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic [K_WIDTH-1:0]   k_len;
  logic                 sat_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, k_len, sat_en, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, k_len, sat_en, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/config_tree_accumulator_sat_adder.sv
// One-bit-wide-guard adder with overflow detect and wrap/saturate select.
module config_sat_adder
  import config_tree_accumulator_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic [IN_WIDTH-1:0]  in_i,
  input  logic                 sat_en_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 ovf_o
);
  localparam int unsigned      SW      = ACC_WIDTH + 1;
  localparam logic [63:0]      MAX64   = acc_max_bits(ACC_WIDTH);
  localparam logic [63:0]      MIN64   = acc_min_bits(ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = MAX64[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = MIN64[ACC_WIDTH-1:0];

  logic [ACC_WIDTH:0] sum_wide;

  assign sum_wide = {acc_i[ACC_WIDTH-1], acc_i} + SW'($signed(in_i));

  // Guard bit disagreeing with the result sign bit means overflow; its value is the true sign.
  always_comb begin
    ovf_o = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    sum_o = sum_wide[ACC_WIDTH-1:0];
    if (ovf_o && sat_en_i) begin
      sum_o = sum_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
endmodule

// File: rtl/config_tree_accumulator.sv
// Accumulates K signed tree-adder sums per result and presents each on a valid/ready port.
module config_tree_accumulator
  import config_tree_accumulator_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned K_WIDTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  config_tree_accumulator_if.slave  bus
);
  if (ACC_WIDTH < IN_WIDTH) begin : g_width_chk
    $fatal(1, "config_tree_accumulator: ACC_WIDTH must be >= IN_WIDTH");
  end

  localparam logic [K_WIDTH-1:0] K_ONE = K_WIDTH'(1);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [K_WIDTH-1:0]   cnt_q, cnt_d;
  logic [K_WIDTH-1:0]   len_q, len_d;
  logic                 sat_q, sat_d;
  logic                 ovf_q, ovf_d;

  logic                 in_ready;
  logic                 first_beat;
  logic [K_WIDTH-1:0]   cnt_inc;
  logic [ACC_WIDTH-1:0] in_sext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;

  assign cnt_inc = cnt_q + K_ONE;
  assign in_sext = ACC_WIDTH'($signed(bus.in_data));

  config_sat_adder #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_adder (
    .acc_i    (acc_q),
    .in_i     (bus.in_data),
    .sat_en_i (sat_q),
    .sum_o    (add_sum),
    .ovf_o    (add_ovf)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and input-ready; a first beat can start from IDLE or from an accepted HOLD.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    in_ready   = 1'b0;
    first_beat = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready   = 1'b1;
        first_beat = bus.in_valid;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) first_beat = 1'b1;
          else              state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (first_beat) begin
      len_d   = (bus.k_len == '0) ? K_ONE : bus.k_len;
      sat_d   = bus.sat_en;
      acc_d   = in_sext;
      ovf_d   = 1'b0;
      cnt_d   = K_ONE;
      state_d = (len_d == K_ONE) ? ST_HOLD : ST_ACCUM;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_config_tree_accumulator.sv
// Directed bench for config_tree_accumulator: vector table plus multi-cycle corner sequences.
module tb_config_tree_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  config_tree_accumulator_if #(.IN_WIDTH(32), .ACC_WIDTH(32), .K_WIDTH(16)) bus ();

  config_tree_accumulator #(
    .IN_WIDTH  (32),
    .ACC_WIDTH (32),
    .K_WIDTH   (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0]      k;
    logic             sat;
    int unsigned      n;
    logic [3:0][31:0] beats;
    logic [31:0]      exp;
    logic             ovf;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input int k, input bit sat, input int unsigned n,
                              input int b0, input int b1, input int b2, input int b3,
                              input int exp_v, input bit ovf);
    vec_t v;
    v.k = 16'(k);
    v.sat = sat;
    v.n = n;
    v.beats[0] = b0;
    v.beats[1] = b1;
    v.beats[2] = b2;
    v.beats[3] = b3;
    v.exp = exp_v;
    v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Drives n beats back to back, mangling k_len/sat_en after the first, then checks result timing.
  task automatic run_vec(input vec_t v, input string tag);
    for (int unsigned i = 0; i < v.n; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = v.beats[i];
      bus.k_len    = (i == 0) ? v.k : 16'hFFFF;
      bus.sat_en   = (i == 0) ? v.sat : ~v.sat;
    end
    @(negedge clk);
    check({tag, "_valid_early"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.out_data), 64'(v.exp));
    check({tag, "_ovf"}, 64'(bus.out_ovf), 64'(v.ovf));
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int vals[8];

    vecs[0] = mk(4, 0, 4, 10, -3, 7, 100, 114, 0);
    vecs[1] = mk(2, 1, 2, 32'h7FFFFFF0, 32'h20, 0, 0, 32'h7FFFFFFF, 1);
    vecs[2] = mk(2, 0, 2, 32'h7FFFFFF0, 32'h20, 0, 0, 32'h80000010, 1);
    vecs[3] = mk(2, 1, 2, 32'h80000000, -1, 0, 0, 32'h80000000, 1);
    vecs[4] = mk(3, 1, 3, 32'h7FFFFFFF, 1, -5, 0, 32'h7FFFFFFA, 1);
    vecs[5] = mk(3, 0, 3, 32'h7FFFFFFF, 1, -5, 0, 32'h7FFFFFFB, 1);
    vecs[6] = mk(2, 0, 2, 1, 2, 0, 0, 3, 0);
    vecs[7] = mk(1, 0, 1, -42, 0, 0, 0, -42, 0);
    vecs[8] = mk(0, 0, 1, 9, 0, 0, 0, 9, 0);
    vecs[9] = mk(4, 1, 4, -100, 50, -25, 200, 125, 0);

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.k_len     = '0;
    bus.sat_en    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Result stalled by out_ready=0 with an upstream beat waiting
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = -5;
      bus.k_len    = 16'd3;
      bus.sat_en   = 1'b0;
    end
    @(posedge clk); #1;
    bus.in_data = 99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_data", 64'(bus.out_data), 64'(32'hFFFFFFF1));
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("stall_accept_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    check("stall_idle_valid", 64'(bus.out_valid), 64'd0);
    check("stall_idle_in_ready", 64'(bus.in_ready), 64'd1);
    run_vec(mk(1, 0, 1, 5, 0, 0, 0, 5, 0), "after_stall");

    // Back-to-back single-beat results, k_len=1 then k_len=0
    for (int i = 0; i < 8; i++) vals[i] = i + 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = vals[i];
      bus.k_len    = (i < 4) ? 16'd1 : 16'd0;
      bus.sat_en   = 1'b0;
      @(negedge clk);
      check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      if (i > 0) begin
        check("b2b_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_data", 64'(bus.out_data), 64'(vals[i-1]));
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_data", 64'(bus.out_data), 64'(vals[7]));
    @(negedge clk);
    check("b2b_drop", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of accumulation discards the partial sum
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = i + 1;
      bus.k_len    = 16'd4;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_accum_valid", 64'(bus.out_valid), 64'd0);
    check("rst_accum_data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(2, 0, 2, 3, 4, 0, 0, 7, 0), "post_rst");

    // Reset while a result is held discards it
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 50;
    bus.k_len    = 16'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("hold_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", 64'(bus.out_valid), 64'd0);
    check("rst_hold_data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Bubbles between beats; k_len/sat_en changed mid-result must be ignored
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 32'h7FFFFFFF; bus.k_len = 16'd3; bus.sat_en = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.k_len = 16'd1; bus.sat_en = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("bubble_no_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = -10; bus.k_len = 16'd7;
    @(negedge clk);
    check("bubble_valid_early", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bubble_valid", 64'(bus.out_valid), 64'd1);
    check("bubble_data", 64'(bus.out_data), 64'(32'h7FFFFFF5));
    check("bubble_ovf", 64'(bus.out_ovf), 64'd1);
    @(negedge clk);
    check("bubble_drop", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
